// File: rtl/nmea_parser_if.sv
// Byte stream from the UART character deserializer into the NMEA parser.
// The master drives one byte per cycle in which i_valid is high.
interface nmea_byte_if;
  logic       i_valid;
  logic [7:0] i_char;

  modport master (output i_valid, output i_char);
  modport slave  (input  i_valid, input  i_char);
endinterface

// File: rtl/nmea_parser.sv
// NMEA sentence receiver: "$ttsss,f,...*HH<CR><LF>" framing, XOR checksum, field
// counting and single-field capture, with a one-cycle result pulse per sentence.
module nmea_parser #(
  parameter int  MAX_FIELDS  = 32,
  parameter int  FIELD_SEL   = 1,
  parameter int  FIELD_BYTES = 12,
  parameter int  MAX_LEN     = 82,
  parameter int  LOWER_HEX   = 1,
  localparam int FCNT_W      = $clog2(MAX_FIELDS + 1),
  localparam int FLEN_W      = $clog2(FIELD_BYTES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  nmea_byte_if.slave               rx,
  output logic                     o_done,
  output logic                     o_check,
  output logic [2:0]               o_err,
  output logic [15:0]              o_talker,
  output logic [23:0]              o_sentence,
  output logic [FCNT_W-1:0]        o_fieldcnt,
  output logic [8*FIELD_BYTES-1:0] o_field_data,
  output logic [FLEN_W-1:0]        o_field_len,
  output logic                     o_busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CK   = 3'd3;
  localparam logic [2:0] ST_CR   = 3'd4;
  localparam logic [2:0] ST_LF   = 3'd5;

  localparam logic [2:0] E_NONE    = 3'd0;
  localparam logic [2:0] E_SUM     = 3'd1;
  localparam logic [2:0] E_HEX     = 3'd2;
  localparam logic [2:0] E_EOL     = 3'd3;
  localparam logic [2:0] E_OVF     = 3'd4;
  localparam logic [2:0] E_RESTART = 3'd5;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  // Returns {digit_valid, nibble}; an invalid digit yields nibble 0.
  function automatic logic [4:0] hex_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'b0_0000;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if (c >= 8'h41 && c <= 8'h46) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else if (LOWER_HEX != 0 && c >= 8'h61 && c <= 8'h66) begin
      r = {1'b1, c[3:0] + 4'd9};
    end else begin
      r = 5'b0_0000;
    end
    return r;
  endfunction

  logic [2:0]               state_r;
  logic [7:0]               xor_r;
  logic [LEN_W-1:0]         len_r;
  logic [2:0]               addr_cnt_r;
  logic [15:0]              talker_r;
  logic [23:0]              sentence_r;
  logic [FCNT_W-1:0]        fidx_r;
  logic [8*FIELD_BYTES-1:0] cap_r;
  logic [FLEN_W-1:0]        cap_len_r;
  logic [7:0]               hex_r;
  logic                     hex_lo_r;
  logic                     bad_hex_r;

  logic       fin_s;
  logic       start_s;
  logic       take_s;
  logic [2:0] err_s;
  logic [4:0] hex_s;

  assign hex_s = hex_nibble(rx.i_char);

  // Classify the incoming byte: start a sentence, finish one (with which error), or consume it.
  always_comb begin
    fin_s   = 1'b0;
    start_s = 1'b0;
    take_s  = 1'b0;
    err_s   = E_NONE;
    if (!rx.i_valid) begin
      fin_s = 1'b0;
    end else if (state_r == ST_IDLE) begin
      start_s = (rx.i_char == CH_DOLLAR);
    end else if (len_r == LEN_W'(MAX_LEN)) begin
      fin_s = 1'b1;
      err_s = E_OVF;
    end else if (rx.i_char == CH_DOLLAR &&
                 (state_r == ST_ADDR || state_r == ST_DATA || state_r == ST_CK)) begin
      fin_s   = 1'b1;
      err_s   = E_RESTART;
      start_s = 1'b1;
    end else begin
      take_s = 1'b1;
      case (state_r)
        ST_CR: begin
          if (rx.i_char != CH_CR) begin
            fin_s = 1'b1;
            err_s = E_EOL;
          end else begin
            fin_s = 1'b0;
          end
        end
        ST_LF: begin
          fin_s = 1'b1;
          if (rx.i_char != CH_LF) begin
            err_s = E_EOL;
          end else if (bad_hex_r) begin
            err_s = E_HEX;
          end else if (hex_r != xor_r) begin
            err_s = E_SUM;
          end else begin
            err_s = E_NONE;
          end
        end
        default: fin_s = 1'b0;
      endcase
    end
  end

  // Sentence state, accumulators and the result registers latched on each finish.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      xor_r        <= 8'h00;
      len_r        <= '0;
      addr_cnt_r   <= 3'd0;
      talker_r     <= 16'h0000;
      sentence_r   <= 24'h000000;
      fidx_r       <= '0;
      cap_r        <= '0;
      cap_len_r    <= '0;
      hex_r        <= 8'h00;
      hex_lo_r     <= 1'b0;
      bad_hex_r    <= 1'b0;
      o_done       <= 1'b0;
      o_check      <= 1'b0;
      o_err        <= 3'd0;
      o_talker     <= 16'h0000;
      o_sentence   <= 24'h000000;
      o_fieldcnt   <= '0;
      o_field_data <= '0;
      o_field_len  <= '0;
      o_busy       <= 1'b0;
    end else begin
      o_done <= fin_s;
      o_busy <= start_s | (~fin_s & (state_r != ST_IDLE));
      // Results snapshot the pre-clear sentence registers, so a restart reports the aborted one.
      if (fin_s) begin
        o_check      <= (err_s == E_NONE);
        o_err        <= err_s;
        o_talker     <= talker_r;
        o_sentence   <= sentence_r;
        o_fieldcnt   <= fidx_r;
        o_field_data <= cap_r;
        o_field_len  <= cap_len_r;
      end
      if (start_s) begin
        state_r    <= ST_ADDR;
        xor_r      <= 8'h00;
        len_r      <= LEN_W'(1);
        addr_cnt_r <= 3'd0;
        talker_r   <= 16'h0000;
        sentence_r <= 24'h000000;
        fidx_r     <= '0;
        cap_r      <= '0;
        cap_len_r  <= '0;
        hex_r      <= 8'h00;
        hex_lo_r   <= 1'b0;
        bad_hex_r  <= 1'b0;
      end else if (fin_s) begin
        state_r <= ST_IDLE;
      end else if (take_s) begin
        len_r <= len_r + LEN_W'(1);
        case (state_r)
          ST_ADDR: begin
            xor_r      <= xor_r ^ rx.i_char;
            addr_cnt_r <= addr_cnt_r + 3'd1;
            case (addr_cnt_r)
              3'd0:    talker_r[15:8]    <= rx.i_char;
              3'd1:    talker_r[7:0]     <= rx.i_char;
              3'd2:    sentence_r[23:16] <= rx.i_char;
              3'd3:    sentence_r[15:8]  <= rx.i_char;
              default: sentence_r[7:0]   <= rx.i_char;
            endcase
            if (addr_cnt_r == 3'd4) begin
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (rx.i_char == CH_STAR) begin
              state_r <= ST_CK;
            end else if (rx.i_char == CH_COMMA) begin
              xor_r <= xor_r ^ rx.i_char;
              if (fidx_r != FCNT_W'(MAX_FIELDS)) begin
                fidx_r <= fidx_r + FCNT_W'(1);
              end
            end else begin
              xor_r <= xor_r ^ rx.i_char;
              if (fidx_r == FCNT_W'(FIELD_SEL) && cap_len_r < FLEN_W'(FIELD_BYTES)) begin
                cap_len_r <= cap_len_r + FLEN_W'(1);
                for (int i = 0; i < FIELD_BYTES; i++) begin
                  if (cap_len_r == FLEN_W'(i)) begin
                    cap_r[8*i +: 8] <= rx.i_char;
                  end
                end
              end
            end
          end
          ST_CK: begin
            hex_r    <= {hex_r[3:0], hex_s[3:0]};
            hex_lo_r <= ~hex_lo_r;
            if (!hex_s[4]) begin
              bad_hex_r <= 1'b1;
            end
            if (hex_lo_r) begin
              state_r <= ST_CR;
            end
          end
          ST_CR:   state_r <= ST_LF;
          default: state_r <= state_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nmea_parser.sv
// Self-checking bench for nmea_parser: directed sentences with literal expectations
// plus random sentence streams scored against a sentence-level reference model.
`timescale 1ns/1ps
module tb_nmea_parser;
  localparam int MF  = 32;
  localparam int FS  = 2;
  localparam int FB  = 12;
  localparam int ML  = 82;
  localparam int FCW = $clog2(MF + 1);
  localparam int FLW = $clog2(FB + 1);

  localparam logic [7:0] C_DOL  = 8'h24;
  localparam logic [7:0] C_STAR = 8'h2A;
  localparam logic [7:0] C_COM  = 8'h2C;
  localparam logic [7:0] C_CR   = 8'h0D;
  localparam logic [7:0] C_LF   = 8'h0A;

  typedef struct packed {
    int              cyc;
    logic            check;
    logic [2:0]      err;
    logic [15:0]     talker;
    logic [23:0]     sentence;
    logic [FCW-1:0]  fcnt;
    logic [8*FB-1:0] fdata;
    logic [FLW-1:0]  flen;
    logic            busy;
  } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            o_done, o_check, o_busy;
  logic [2:0]      o_err;
  logic [15:0]     o_talker;
  logic [23:0]     o_sentence;
  logic [FCW-1:0]  o_fieldcnt;
  logic [8*FB-1:0] o_field_data;
  logic [FLW-1:0]  o_field_len;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_done_cyc;
  res_t obs_q[$];
  res_t exp_q[$];
  res_t mon_r;
  logic [7:0] cur[$];
  bit         in_sent;
  logic [7:0] gen_q[$];

  nmea_byte_if bus ();

  nmea_parser #(
    .MAX_FIELDS(MF), .FIELD_SEL(FS), .FIELD_BYTES(FB), .MAX_LEN(ML), .LOWER_HEX(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .rx(bus),
    .o_done(o_done), .o_check(o_check), .o_err(o_err), .o_talker(o_talker),
    .o_sentence(o_sentence), .o_fieldcnt(o_fieldcnt), .o_field_data(o_field_data),
    .o_field_len(o_field_len), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      mon_r.cyc      = cyc;
      mon_r.check    = o_check;
      mon_r.err      = o_err;
      mon_r.talker   = o_talker;
      mon_r.sentence = o_sentence;
      mon_r.fcnt     = o_fieldcnt;
      mon_r.fdata    = o_field_data;
      mon_r.flen     = o_field_len;
      mon_r.busy     = o_busy;
      obs_q.push_back(mon_r);
    end
  end

  // ---------------- reference model (works on the whole buffered sentence) ----------------
  function automatic bit hex_ok(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c <= 8'h39) return int'(c) - 48;
    else if (c <= 8'h46) return int'(c) - 55;
    else return int'(c) - 87;
  endfunction

  function automatic int find_star();
    for (int i = 6; i < cur.size(); i++) if (cur[i] == C_STAR) return i;
    return -1;
  endfunction

  task automatic model_finish(input logic [2:0] err, input int at);
    res_t r;
    int   n, st, de, fi, fl;
    r = '0;
    n = cur.size();
    st = find_star();
    de = (st >= 0) ? st : n;
    fi = 0;
    fl = 0;
    r.cyc = at;
    r.err = err;
    r.check = (err == 3'd0);
    r.busy = (err == 3'd5);
    if (n > 1) r.talker[15:8] = cur[1];
    if (n > 2) r.talker[7:0] = cur[2];
    if (n > 3) r.sentence[23:16] = cur[3];
    if (n > 4) r.sentence[15:8] = cur[4];
    if (n > 5) r.sentence[7:0] = cur[5];
    for (int i = 6; i < de; i++) begin
      if (cur[i] == C_COM) fi++;
      else if (fi == FS && fl < FB) begin
        r.fdata[8*fl +: 8] = cur[i];
        fl++;
      end
    end
    r.fcnt = FCW'((fi > MF) ? MF : fi);
    r.flen = FLW'(fl);
    exp_q.push_back(r);
  endtask

  task automatic model_byte(input logic [7:0] c, input int at);
    int n, st, k, ph;
    logic [7:0] sum;
    if (!in_sent) begin
      if (c == C_DOL) begin
        in_sent = 1'b1;
        cur.delete();
        cur.push_back(c);
      end
      return;
    end
    n = cur.size();
    if (n == ML) begin
      model_finish(3'd4, at);
      in_sent = 1'b0;
      return;
    end
    st = find_star();
    if (n < 6) ph = 0;
    else if (st < 0) ph = 1;
    else begin
      k = n - 1 - st;
      ph = (k < 2) ? 2 : ((k == 2) ? 3 : 4);
    end
    if (c == C_DOL && ph <= 2) begin
      model_finish(3'd5, at);
      cur.delete();
      cur.push_back(c);
    end else if (ph == 3) begin
      if (c != C_CR) begin
        model_finish(3'd3, at);
        in_sent = 1'b0;
      end else cur.push_back(c);
    end else if (ph == 4) begin
      if (c != C_LF) model_finish(3'd3, at);
      else if (!hex_ok(cur[st+1]) || !hex_ok(cur[st+2])) model_finish(3'd2, at);
      else begin
        sum = 8'h00;
        for (int i = 1; i < st; i++) sum ^= cur[i];
        model_finish((int'(sum) == hex_val(cur[st+1]) * 16 + hex_val(cur[st+2])) ? 3'd0 : 3'd1, at);
      end
      in_sent = 1'b0;
    end else cur.push_back(c);
  endtask

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] c);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_char  = c;
    exp_done_cyc = cyc + 1;
    model_byte(c, cyc + 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_char  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b1;
    in_sent = 1'b0;
    cur.delete();
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_txt();
    string pool;
    pool = "0123456789ABCDEFXYZabcxyz.-";
    return pool[$urandom_range(0, pool.len() - 1)];
  endfunction

  function automatic logic [7:0] hex_ch(input logic [3:0] nib, input bit lower);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else if (lower) return 8'h57 + {4'h0, nib};
    else return 8'h37 + {4'h0, nib};
  endfunction

  task automatic gen_sentence();
    int kind, nf, flen, cut;
    logic [7:0] x;
    logic [7:0] body[$];
    kind = $urandom_range(0, 9);
    gen_q.delete();
    for (int i = 0; i < 5; i++) body.push_back(8'h41 + 8'($urandom_range(0, 25)));
    nf = (kind == 6) ? 40 : $urandom_range(0, 5);
    for (int f = 0; f < nf; f++) begin
      body.push_back(C_COM);
      flen = (kind == 4) ? $urandom_range(60, 90) : ((kind == 6) ? 0 : $urandom_range(0, 14));
      for (int j = 0; j < flen; j++) body.push_back(rand_txt());
    end
    x = 8'h00;
    foreach (body[i]) x ^= body[i];
    if (kind == 0) x ^= 8'($urandom_range(1, 255));
    gen_q.push_back(C_DOL);
    foreach (body[i]) gen_q.push_back(body[i]);
    gen_q.push_back(C_STAR);
    gen_q.push_back(hex_ch(x[7:4], kind == 5));
    gen_q.push_back((kind == 1) ? 8'h67 : hex_ch(x[3:0], kind == 5));
    gen_q.push_back((kind == 2) ? 8'h58 : C_CR);
    gen_q.push_back(C_LF);
    if (kind == 3) begin
      cut = $urandom_range(1, gen_q.size() - 3);
      while (gen_q.size() > cut) void'(gen_q.pop_back());
    end
  endtask

  task automatic run_random(input int count, input bit gaps);
    for (int s = 0; s < count; s++) begin
      gen_sentence();
      foreach (gen_q[i]) begin
        send_byte(gen_q[i]);
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      if (gaps && $urandom_range(0, 4) == 0) begin
        for (int j = 0; j < 3; j++) send_byte(rand_txt());
      end
    end
    idle(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (o_done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_check !== 1'b0)  begin errors++; $display("FAIL reset_check: got %b want 0", o_check); end
    checks++; if (o_err !== 3'd0)    begin errors++; $display("FAIL reset_err: got %0d want 0", o_err); end
    checks++; if (o_talker !== 16'h0 || o_sentence !== 24'h0) begin errors++; $display("FAIL reset_addr: got %h %h want 0 0", o_talker, o_sentence); end
    checks++; if (o_fieldcnt !== '0 || o_field_len !== '0 || o_field_data !== '0) begin errors++; $display("FAIL reset_field: got %0d %0d %h want 0", o_fieldcnt, o_field_len, o_field_data); end
    checks++; if (o_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    obs_q.delete();
    send_str("$GPAAA*56");
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", o_busy); end
    send_byte(C_CR);
    send_byte(C_LF);
    idle(3);
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].cyc !== exp_done_cyc) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d", obs_q[0].cyc, exp_done_cyc); end
      checks++; if (obs_q[0].check !== 1'b1 || obs_q[0].err !== 3'd0) begin errors++; $display("FAIL basic_check: got %b/%0d want 1/0", obs_q[0].check, obs_q[0].err); end
      checks++; if (obs_q[0].talker !== 16'h4750 || obs_q[0].sentence !== 24'h414141) begin errors++; $display("FAIL basic_addr: got %h %h want 4750 414141", obs_q[0].talker, obs_q[0].sentence); end
      checks++; if (obs_q[0].fcnt !== '0 || obs_q[0].busy !== 1'b0) begin errors++; $display("FAIL basic_fcnt_busy: got %0d %b want 0 0", obs_q[0].fcnt, obs_q[0].busy); end
    end
  endtask

  task automatic test_fields();
    obs_q.delete();
    send_str("$GPAAA,1,2*55"); send_byte(C_CR); send_byte(C_LF);
    send_str("$GPAAA,1,2*56"); send_byte(C_CR); send_byte(C_LF);
    idle(3);
    checks++;
    if (obs_q.size() !== 2) begin errors++; $display("FAIL fields_count: got %0d want 2", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].check !== 1'b1 || obs_q[0].fcnt !== FCW'(2)) begin errors++; $display("FAIL fields_good: got check %b fcnt %0d want 1 2", obs_q[0].check, obs_q[0].fcnt); end
      checks++; if (obs_q[0].flen !== FLW'(1) || obs_q[0].fdata !== {{(8*FB-8){1'b0}}, 8'h32}) begin errors++; $display("FAIL fields_capture: got len %0d data %h want 1 32", obs_q[0].flen, obs_q[0].fdata); end
      checks++; if (obs_q[1].check !== 1'b0 || obs_q[1].err !== 3'd1) begin errors++; $display("FAIL fields_mismatch: got %b/%0d want 0/1", obs_q[1].check, obs_q[1].err); end
    end
  endtask

  task automatic test_hex();
    obs_q.delete();
    send_str("$GPAAA*5G"); send_byte(C_CR); send_byte(C_LF);
    send_str("$GPAAA,*7a"); send_byte(C_CR); send_byte(C_LF);
    send_str("$GPAAA*g6"); send_byte(C_CR); send_byte(C_LF);
    idle(3);
    checks++;
    if (obs_q.size() !== 3) begin errors++; $display("FAIL hex_count: got %0d want 3", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].err !== 3'd2) begin errors++; $display("FAIL hex_bad: got %0d want 2", obs_q[0].err); end
      checks++; if (obs_q[1].check !== 1'b1) begin errors++; $display("FAIL hex_lower: got check %b err %0d want 1", obs_q[1].check, obs_q[1].err); end
      checks++; if (obs_q[2].err !== 3'd2) begin errors++; $display("FAIL hex_bad_hi: got %0d want 2", obs_q[2].err); end
    end
  endtask

  task automatic test_eol_restart();
    obs_q.delete();
    send_str("$GPAAA*56"); send_byte(C_CR); send_byte(8'h58);
    idle(2);
    send_str("$GPA$GPAAA*56"); send_byte(C_CR); send_byte(C_LF);
    idle(3);
    checks++;
    if (obs_q.size() !== 3) begin errors++; $display("FAIL restart_count: got %0d want 3", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].err !== 3'd3) begin errors++; $display("FAIL eol_err: got %0d want 3", obs_q[0].err); end
      checks++; if (obs_q[1].err !== 3'd5 || obs_q[1].check !== 1'b0 || obs_q[1].busy !== 1'b1) begin errors++; $display("FAIL restart_err: got %0d/%b/%b want 5/0/1", obs_q[1].err, obs_q[1].check, obs_q[1].busy); end
      checks++; if (obs_q[2].check !== 1'b1 || obs_q[2].talker !== 16'h4750) begin errors++; $display("FAIL restart_next: got %b %h want 1 4750", obs_q[2].check, obs_q[2].talker); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0]      c;
    logic [8*FB-1:0] fexp;
    int              ovf_cyc;
    obs_q.delete();
    fexp = '0;
    ovf_cyc = 0;
    send_str("$GPAAA,X,");
    for (int i = 0; i < 90; i++) begin
      c = 8'h41 + 8'($urandom_range(0, 25));
      if (i < FB) fexp[8*i +: 8] = c;
      send_byte(c);
      if (9 + i == ML) ovf_cyc = exp_done_cyc;
    end
    idle(3);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ovf_idle_busy: got %b want 0", o_busy); end
    checks++;
    if (obs_q.size() !== 1) begin errors++; $display("FAIL ovf_count: got %0d want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0].err !== 3'd4 || obs_q[0].cyc !== ovf_cyc) begin errors++; $display("FAIL ovf_err: got %0d at %0d want 4 at %0d", obs_q[0].err, obs_q[0].cyc, ovf_cyc); end
      checks++; if (obs_q[0].busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b want 0", obs_q[0].busy); end
      checks++; if (obs_q[0].flen !== FLW'(FB) || obs_q[0].fdata !== fexp) begin errors++; $display("FAIL ovf_capture: got %0d %h want %0d %h", obs_q[0].flen, obs_q[0].fdata, FB, fexp); end
    end
  endtask

  task automatic test_midreset();
    obs_q.delete();
    send_str("$GPA");
    apply_reset();
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses want 0", obs_q.size()); end
    checks++; if (o_talker !== 16'h0 || o_field_data !== '0 || o_busy !== 1'b0 || o_err !== 3'd0) begin errors++; $display("FAIL midrst_outputs: got %h %h %b %0d want zeros", o_talker, o_field_data, o_busy, o_err); end
    rst = 1'b0;
    send_str("$GPAAA*56"); send_byte(C_CR); send_byte(C_LF);
    idle(3);
    checks++; if (obs_q.size() !== 1 || obs_q[0].check !== 1'b1) begin errors++; $display("FAIL midrst_next: got %0d pulses want 1 with check", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    run_random(40, 1'b0);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    obs_q.delete();
    exp_q.delete();
    run_random(60, 1'b1);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_char = 8'h00;
    in_sent = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_fields();
    test_hex();
    test_eol_restart();
    test_overflow();
    test_midreset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmea_parser.md
Name: nmea_parser

Overview:
- Parametrised successor to the NMEA sentence receiver.
- Consumes a byte stream from the UART character deserializer, one byte per i_valid pulse.
- Parses "$" + 2-char talker ID + 3-char sentence ID + ",field,..." + "*HH" + CR LF.
- Checks the XOR checksum, counts fields, captures one selectable field into a byte buffer, and reports a per-sentence result with an error code.

Parameters:
- MAX_FIELDS, 32: saturation limit for the field counter; o_fieldcnt width is clog2(MAX_FIELDS+1).
- FIELD_SEL, 1: index (1-based) of the data field captured into o_field_data.
- FIELD_BYTES, 12: capacity of the field capture buffer, in bytes.
- MAX_LEN, 82: maximum number of bytes from "$" through LF inclusive. A sentence exceeding this is aborted.
- LOWER_HEX, 1: when 1, checksum hex digits a-f are accepted as well as A-F.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  i_char valid this cycle
- i_char  in  8  received byte
- o_done  out  1  one-cycle pulse: sentence finished (good or bad)
- o_check  out  1  valid with o_done: 1 = checksum matched and no error
- o_err  out  3  valid with o_done: 0 none, 1 checksum mismatch, 2 bad hex digit, 3 missing CR/LF, 4 overflow (MAX_LEN), 5 restart ("$" mid-sentence)
- o_talker  out  16  [15:8] = first talker char, [7:0] = second
- o_sentence  out  24  [23:16] = first sentence-ID char … [7:0] = third
- o_fieldcnt  out  clog2(MAX_FIELDS+1)  number of commas seen in DATA, saturating at MAX_FIELDS
- o_field_data  out  8*FIELD_BYTES  captured field; byte 0 at [7:0]; unused bytes are 0
- o_field_len  out  clog2(FIELD_BYTES+1)  number of bytes captured
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, internal XOR, length, hex and field registers 0.
- Nothing advances without i_valid. When i_valid is low, all state holds.
- States and transitions:
  - IDLE: "$" → ADDR. Clear XOR, length, field count and capture; set length to 1. Any other byte is ignored.
  - ADDR: takes 5 bytes. Bytes 0-1 go to the talker register, bytes 2-4 to the sentence register; each byte is XORed in. After byte 4 → DATA.
  - DATA:
    - "*" → CK. The "*" is not XORed.
    - "," is XORed and increments the field index.
    - Any other byte is XORed. If field index == FIELD_SEL and fewer than FIELD_BYTES bytes are captured, it is appended to the capture buffer. Excess bytes are silently dropped.
  - CK: takes 2 hex digits, high nibble first. A non-hex byte sets a sticky bad_hex flag. After the 2nd digit → CR.
  - CR: 0x0D → LF; anything else → finish with err 3.
  - LF: 0x0A → finish; anything else → finish with err 3.
- Finish:
  - In the cycle after the accepting i_valid: o_done=1 for exactly one cycle.
  - o_talker, o_sentence, o_fieldcnt, o_field_data and o_field_len update together with o_done and hold until the next o_done.
  - Error priority: bad hex (2) > mismatch (1). o_check = (err == 0).
  - State returns to IDLE.
- Length: incremented on every accepted byte while not IDLE. A byte that would make length exceed MAX_LEN → finish with err 4; the byte is discarded.
- Restart: "$" in ADDR, DATA or CK → finish with err 5 (o_done pulse), then immediately treat the byte as a new "$" (state ADDR, counters cleared). There is no lost-byte penalty.
- The field index wraps never; it saturates at MAX_FIELDS.
- Reset asserted mid-sentence: abort silently, no o_done, all outputs to 0.
- Back-to-back sentences with no idle cycles between bytes are supported. Throughput is one byte per clock.

Test Plan:
- "$GPAAA*56\r\n" → o_done=1, o_check=1, o_err=0, o_talker=16'h4750, o_sentence=24'h414141, o_fieldcnt=0.
- "$GPAAA,1,2*55\r\n" with FIELD_SEL=2 → o_check=1, o_fieldcnt=2, o_field_len=1, o_field_data[7:0]=8'h32. Repeat with "*56" → o_check=0, o_err=1.
- "$GPAAA*5G\r\n" → o_err=2. With LOWER_HEX=1, a sentence whose checksum is "7a" sent as "*7a" → o_check=1.
- "$GPAAA*56\rX" → o_err=3. Then "$GPA$GPAAA*56\r\n" → first o_done with o_err=5, second o_done with o_check=1.
- 90-byte DATA run with MAX_LEN=82 → o_err=4 on the 83rd byte, o_busy=0. A field longer than FIELD_BYTES gives o_field_len=FIELD_BYTES.
- i_rst pulsed after "$GPA" → no o_done, all outputs 0. The following full valid sentence parses with o_check=1.
